dmem_lsu: RTL and testbench
===========================

# dmem_lsu

Load/store unit sitting directly upstream of the data memory: accepts one load or store per request from the core's memory stage and sequences the word-only, combinational-read data memory. Provides byte/halfword/word accesses:
- sub-word stores via a read-modify-write sequence;
- loads with lane extraction and sign/zero extension;
- misaligned and reserved-size requests rejected with an error response.

## Interface

Parameters:
- ADDR_WIDTH, 32, byte address width on both core and memory sides
- DATA_WIDTH, 32, word width; fixed at 32 (four byte lanes)

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- req_i  in  1  core request; accepted on a rising edge with req_i && gnt_o
- we_i  in  1  1 = store, 0 = load
- size_i  in  2  access size (lsu_size_e): 00 byte, 01 half, 10 word, 11 reserved
- unsigned_i  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- addr_i  in  ADDR_WIDTH  byte address
- wdata_i  in  DATA_WIDTH  store data, right-aligned (bits [7:0] for byte, [15:0] for half)
- gnt_o  out  1  ready to accept a request; high only in IDLE
- rvalid_o  out  1  one-cycle completion pulse for every accepted request
- rdata_o  out  DATA_WIDTH  extended load data; 0 for stores and errors; valid with rvalid_o
- err_o  out  1  misaligned or reserved-size request; valid with rvalid_o
- mem_en_o  out  1  data memory enable
- mem_we_o  out  1  data memory write enable
- mem_addr_o  out  ADDR_WIDTH  word-aligned address {addr[ADDR_WIDTH-1:2], 2'b00}
- mem_wdata_o  out  DATA_WIDTH  full word to write
- mem_rdata_i  in  DATA_WIDTH  memory read data, combinational, valid in the same cycle as mem_en_o && !mem_we_o

## Operation

- FSM states (lsu_state_e): IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP.
- IDLE, gnt_o=1. On acceptance, latch we, size, unsigned, addr, wdata, then branch:
  - size 11, half with addr[0]=1, or word with addr[1:0]!=0 → RESP with err set; no memory access.
  - Load → LOAD.
  - Word store → STORE.
  - Byte or half store → RMW_RD.
- LOAD: mem_en=1, we=0. Extract the lane from mem_rdata_i: byte at bits [8*addr[1:0] +: 8], half at [16*addr[1] +: 16]. Extend per unsigned, register into rdata_o. → RESP.
- RMW_RD: mem_en=1, we=0. Capture mem_rdata_i into the merge buffer. → RMW_WR.
- RMW_WR: mem_en=1, we=1. mem_wdata_o is the merge buffer with the addressed lane(s) replaced by wdata. → RESP.
- STORE: mem_en=1, we=1, mem_wdata_o = wdata. → RESP.
- RESP: rvalid_o=1, err_o per latch. → IDLE.
- Memory-side outputs derive from state and latched registers only, never from core inputs. Outside the access states: mem_en_o, mem_we_o, mem_addr_o and mem_wdata_o are all 0.
- Little-endian byte lanes. req_i is ignored while gnt_o=0; the core must hold or drop it.

## Timing

- Request accepted at edge N:
  - error: rvalid_o high in cycle N+1
  - load, word store: rvalid_o high in cycle N+2
  - sub-word store: rvalid_o high in cycle N+3
- gnt_o is 0 from the cycle after acceptance through RESP, so at most one request is in flight. The next request can be accepted on the edge that ends RESP.
- rdata_o and err_o hold their values until the next RESP. rvalid_o is never high for two consecutive cycles.
- Reset values: state IDLE, gnt_o=1, rvalid_o=0, rdata_o=0, err_o=0, all mem_* outputs 0, latches and merge buffer 0.
- Reset asserted mid-operation (including during STORE or RMW_WR): the request is discarded and mem_en_o/mem_we_o drop immediately. No write occurs on any edge where reset is asserted, and no rvalid_o is produced for the discarded request.

## Structure

- Shared package cpu_pkg holds lsu_size_e (LSU_BYTE, LSU_HALF, LSU_WORD, LSU_RSVD) and lsu_state_e.
- One combinational sub-module, lsu_align, provides:
  - the misalignment check;
  - load lane extraction and extension;
  - store lane merge.
- The dmem_lsu top holds the FSM, request latches and the merge buffer.

## Test plan

- Reset: assert rst_i asynchronously mid-cycle → all outputs at the reset values immediately, gnt_o=1.
- Word store 0xDEADBEEF to 0x100, then lw 0x100 → one write cycle with mem_addr_o=0x100; load rvalid_o at N+2, rdata_o=0xDEADBEEF, err_o=0.
- sb 0xAB to 0x102 over 0xDEADBEEF → read cycle, then write cycle with mem_wdata_o=0xDEABBEEF; lb 0x102 → 0xFFFFFFAB; lbu 0x102 → 0x000000AB.
- sh 0x8001 to 0x106 over a zero word → memory word 0x80010000; lh 0x106 → 0xFFFF8001; lhu 0x106 → 0x00008001.
- lh 0x101, sw 0x102 and size 11 → err_o=1, rvalid_o at N+1, rdata_o=0, mem_en_o never asserted.
- rst_i pulsed during RMW_WR of sb 0x55 to 0x100 → word 0x100 unchanged; after release, lw 0x100 is accepted and returns the old value.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types for the core's memory stage: access sizes and load/store unit states.
package cpu_pkg;

  typedef enum logic [1:0] {
    LSU_BYTE = 2'b00,
    LSU_HALF = 2'b01,
    LSU_WORD = 2'b10,
    LSU_RSVD = 2'b11
  } lsu_size_e;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STORE,
    RMW_RD,
    RMW_WR,
    RESP
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane logic for the load/store unit: alignment check on the incoming request,
// load lane extraction with extension, and sub-word merge into a read-back word.
module lsu_align
  import cpu_pkg::*;
(
  input  lsu_size_e   chk_size_i,
  input  logic [1:0]  chk_off_i,
  output logic        misaligned_o,
  input  lsu_size_e   size_i,
  input  logic [1:0]  off_i,
  input  logic        unsigned_i,
  input  logic [31:0] load_word_i,
  output logic [31:0] load_data_o,
  input  logic [31:0] merge_word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] merged_o
);

  logic [7:0]  byteLane;
  logic [15:0] halfLane;

  always_comb begin
    case (chk_size_i)
      LSU_BYTE: misaligned_o = 1'b0;
      LSU_HALF: misaligned_o = chk_off_i[0];
      LSU_WORD: misaligned_o = (chk_off_i != 2'b00);
      default:  misaligned_o = 1'b1;
    endcase
  end

  // Little-endian lanes: byte n lives in bits [8n +: 8].
  always_comb begin
    byteLane = load_word_i[8*off_i +: 8];
    halfLane = load_word_i[16*off_i[1] +: 16];
    case (size_i)
      LSU_BYTE: load_data_o = unsigned_i ? {24'b0, byteLane} : {{24{byteLane[7]}}, byteLane};
      LSU_HALF: load_data_o = unsigned_i ? {16'b0, halfLane} : {{16{halfLane[15]}}, halfLane};
      default:  load_data_o = load_word_i;
    endcase
  end

  always_comb begin
    merged_o = merge_word_i;
    case (size_i)
      LSU_BYTE: merged_o[8*off_i +: 8]       = wdata_i[7:0];
      LSU_HALF: merged_o[16*off_i[1] +: 16]  = wdata_i[15:0];
      default:  merged_o                     = wdata_i;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit in front of a word-only, combinational-read data memory.
// Sub-word stores are done as read-modify-write; bad requests get an error response.
module dmem_lsu
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [1:0]            size_i,
  input  logic                  unsigned_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  gnt_o,
  output logic                  rvalid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  err_o,
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  lsu_state_e            state_q, state_d;
  logic                  we_q;
  lsu_size_e             size_q;
  logic                  uns_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] buf_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;

  lsu_size_e             reqSize;
  logic                  reqMisaligned;
  logic [DATA_WIDTH-1:0] loadData;
  logic [DATA_WIDTH-1:0] mergedWord;
  logic [ADDR_WIDTH-1:0] wordAddr;

  assign reqSize  = lsu_size_e'(size_i);
  assign wordAddr = {addr_q[ADDR_WIDTH-1:2], 2'b00};

  lsu_align u_align (
    .chk_size_i   (reqSize),
    .chk_off_i    (addr_i[1:0]),
    .misaligned_o (reqMisaligned),
    .size_i       (size_q),
    .off_i        (addr_q[1:0]),
    .unsigned_i   (uns_q),
    .load_word_i  (mem_rdata_i),
    .load_data_o  (loadData),
    .merge_word_i (buf_q),
    .wdata_i      (wdata_q),
    .merged_o     (mergedWord)
  );

  assign gnt_o    = (state_q == IDLE);
  assign rvalid_o = (state_q == RESP);
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          if (reqMisaligned)          state_d = RESP;
          else if (!we_i)             state_d = LOAD;
          else if (reqSize == LSU_WORD) state_d = STORE;
          else                        state_d = RMW_RD;
        end
      end
      LOAD, STORE, RMW_WR: state_d = RESP;
      RMW_RD:              state_d = RMW_WR;
      RESP:                state_d = IDLE;
      default:             state_d = IDLE;
    endcase
  end

  // Memory side is driven purely from state and latched request fields.
  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (state_q)
      LOAD, RMW_RD: begin
        mem_en_o   = 1'b1;
        mem_addr_o = wordAddr;
      end
      STORE: begin
        mem_en_o    = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = wordAddr;
        mem_wdata_o = wdata_q;
      end
      RMW_WR: begin
        mem_en_o    = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = wordAddr;
        mem_wdata_o = mergedWord;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= LSU_BYTE;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      buf_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req_i) begin
        we_q    <= we_i;
        size_q  <= reqSize;
        uns_q   <= unsigned_i;
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
      end
      if (state_q == RMW_RD) buf_q <= mem_rdata_i;
      // Response registers only change on entry to RESP; only IDLE->RESP is an error.
      if (state_d == RESP && state_q != RESP) begin
        rdata_q <= (state_q == LOAD) ? loadData : '0;
        err_q   <= (state_q == IDLE);
      end
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu with a behavioural word memory; responses and
// memory writes are checked by monitors against queued expectations.
module tb_dmem_lsu;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } respExp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } writeExp_t;

  logic        clk = 1'b0;
  logic        rstI = 1'b0;
  logic        reqI = 1'b0;
  logic        weI = 1'b0;
  logic [1:0]  sizeI = 2'b00;
  logic        unsignedI = 1'b0;
  logic [31:0] addrI = '0;
  logic [31:0] wdataI = '0;
  logic        gntO, rvalidO, errO, memEnO, memWeO;
  logic [31:0] rdataO, memAddrO, memWdataO, memRdataI;

  logic [31:0] mem [0:255];
  respExp_t    respQ[$];
  writeExp_t   wrQ[$];
  int          cyc = 0;
  int          memEnCount = 0;
  int          compared = 0;
  int          mismatched = 0;

  dmem_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk_i       (clk),
    .rst_i       (rstI),
    .req_i       (reqI),
    .we_i        (weI),
    .size_i      (sizeI),
    .unsigned_i  (unsignedI),
    .addr_i      (addrI),
    .wdata_i     (wdataI),
    .gnt_o       (gntO),
    .rvalid_o    (rvalidO),
    .rdata_o     (rdataO),
    .err_o       (errO),
    .mem_en_o    (memEnO),
    .mem_we_o    (memWeO),
    .mem_addr_o  (memAddrO),
    .mem_wdata_o (memWdataO),
    .mem_rdata_i (memRdataI)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign memRdataI = mem[memAddrO[9:2]];
  always @(posedge clk) if (memEnO && memWeO) mem[memAddrO[9:2]] <= memWdataO;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Response and memory-write monitors, decoupled from stimulus.
  always @(negedge clk) begin
    if (!rstI) begin
      if (rvalidO) begin
        if (respQ.size() == 0) begin
          checkOutput("unexpected_rvalid", 32'd1, 32'd0);
        end else begin
          respExp_t e;
          e = respQ.pop_front();
          checkOutput("rdata", rdataO, e.rdata);
          checkOutput("err", {31'b0, errO}, {31'b0, e.err});
          checkOutput("rvalid_cycle", cyc, e.due);
        end
      end
      if (memEnO) memEnCount++;
      if (memEnO && memWeO) begin
        if (wrQ.size() == 0) begin
          checkOutput("unexpected_write", memAddrO, 32'hFFFF_FFFF);
        end else begin
          writeExp_t w;
          w = wrQ.pop_front();
          checkOutput("mem_addr", memAddrO, w.addr);
          checkOutput("mem_wdata", memWdataO, w.data);
        end
      end
    end
  end

  // lat: cycles from acceptance to the rvalid cycle (1, 2 or 3); 0 = no response expected.
  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] expRdata, input logic expErr, input int lat);
    int n = 0;
    @(negedge clk);
    while (!gntO && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!gntO) checkOutput("gnt_timeout", 32'd0, 32'd1);
    reqI = 1'b1; weI = we; sizeI = size; unsignedI = uns; addrI = addr; wdataI = wdata;
    @(posedge clk);
    #1;
    if (lat > 0) respQ.push_back('{rdata: expRdata, err: expErr, due: cyc + lat - 1});
    reqI = 1'b0;
  endtask

  task automatic expectWrite(input logic [31:0] addr, input logic [31:0] data);
    wrQ.push_back('{addr: addr, data: data});
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int savedEn;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;

    #2 rstI = 1'b1;
    #1;
    checkOutput("rst_gnt", {31'b0, gntO}, 32'd1);
    checkOutput("rst_rvalid", {31'b0, rvalidO}, 32'd0);
    checkOutput("rst_rdata", rdataO, 32'd0);
    checkOutput("rst_err", {31'b0, errO}, 32'd0);
    checkOutput("rst_mem_en_we", {30'b0, memEnO, memWeO}, 32'd0);
    checkOutput("rst_mem_addr", memAddrO, 32'd0);
    checkOutput("rst_mem_wdata", memWdataO, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rstI = 1'b0;

    expectWrite(32'h100, 32'hDEADBEEF);
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 2);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 2);

    expectWrite(32'h100, 32'hDEABBEEF);
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h102, 32'h000000AB, 32'h0, 1'b0, 3);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h102, 32'h0, 32'hFFFFFFAB, 1'b0, 2);
    applyStimulus(1'b0, 2'b00, 1'b1, 32'h102, 32'h0, 32'h000000AB, 1'b0, 2);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'hFFFFFFDE, 1'b0, 2);
    applyStimulus(1'b0, 2'b00, 1'b1, 32'h101, 32'h0, 32'h000000BE, 1'b0, 2);
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h100, 32'h0, 32'hFFFFBEEF, 1'b0, 2);

    expectWrite(32'h104, 32'h80010000);
    applyStimulus(1'b1, 2'b01, 1'b0, 32'h106, 32'h00008001, 32'h0, 1'b0, 3);
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h106, 32'h0, 32'hFFFF8001, 1'b0, 2);
    applyStimulus(1'b0, 2'b01, 1'b1, 32'h106, 32'h0, 32'h00008001, 1'b0, 2);
    applyStimulus(1'b0, 2'b01, 1'b1, 32'h104, 32'h0, 32'h00000000, 1'b0, 2);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h107, 32'h0, 32'hFFFFFF80, 1'b0, 2);

    repeat (4) @(negedge clk);
    savedEn = memEnCount;
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h101, 32'h0, 32'h0, 1'b1, 1);
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h102, 32'h12345678, 32'h0, 1'b1, 1);
    applyStimulus(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1, 1);
    repeat (4) @(negedge clk);
    checkOutput("err_no_mem_access", memEnCount, savedEn);

    // Abort a byte store while it is in its write cycle.
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h100, 32'h00000055, 32'h0, 1'b0, 0);
    @(posedge clk);
    #2 rstI = 1'b1;
    #1;
    checkOutput("abort_mem_en_we", {30'b0, memEnO, memWeO}, 32'd0);
    checkOutput("abort_gnt", {31'b0, gntO}, 32'd1);
    checkOutput("abort_rvalid", {31'b0, rvalidO}, 32'd0);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    rstI = 1'b0;
    checkOutput("abort_mem_word", mem[32'h100 >> 2], 32'hDEABBEEF);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEABBEEF, 1'b0, 2);

    repeat (6) @(negedge clk);
    checkOutput("resp_queue_drained", respQ.size(), 32'd0);
    checkOutput("write_queue_drained", wrQ.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
